// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel-array frame sequencer.
// Used by pixel_frame_ctrl and pixel_ramp_counter.
package pixel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        DRAIN
    } state_t;

    localparam int unsigned DEF_ADC_BITS = 8;

    // Ramp conversion length in cycles for a given ADC resolution.
    function automatic int unsigned conv_len(input int unsigned bits);
        return 2 ** bits;
    endfunction

    // Width of a row index; never narrower than one bit.
    function automatic int unsigned row_w(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/pixel_ramp_counter.sv
// Ramp-ADC code generator: up-counter with enable, clear and
// terminal-count flag, spanning one full conversion.
module pixel_ramp_counter
    import pixel_pkg::*;
#(
    parameter int BITS = DEF_ADC_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_en,
    input  logic            i_clr,
    output logic [BITS-1:0] o_code,
    output logic            o_tc
);

    localparam logic [BITS-1:0] CODE_LAST = BITS'(conv_len(BITS) - 1);

    logic [BITS-1:0] r_code;

    // Count one ramp step per enabled cycle; clear wins over enable.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_code <= '0;
        end else if (i_en) begin
            r_code <= r_code + BITS'(1);
        end
    end

    assign o_code = r_code;
    assign o_tc   = (r_code == CODE_LAST);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer: erase/expose/convert/read with row streaming.
// Optional macro PIXEL_TEST_PATTERN_EN adds a test_mode data source.
module pixel_frame_ctrl
    import pixel_pkg::*;
#(
    parameter int NUM_ROWS     = 2,
    parameter int NUM_COLS     = 2,
    parameter int ADC_BITS     = DEF_ADC_BITS,
    parameter int ERASE_CYCLES = 4,
    parameter int EXP_W        = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [EXP_W-1:0]             expose_cycles,
`ifdef PIXEL_TEST_PATTERN_EN
    input  logic                         test_mode,
`endif
    output logic                         erase,
    output logic                         ana_reset,
    output logic                         expose,
    output logic                         convert,
    output logic [ADC_BITS-1:0]          adc_code,
    output logic [NUM_ROWS-1:0]          read_row,
    input  logic [NUM_COLS*ADC_BITS-1:0] pix_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_COLS*ADC_BITS-1:0] out_data,
    output logic [row_w(NUM_ROWS)-1:0]   out_row,
    output logic                         out_last,
    output logic                         busy
);

    localparam int RW = row_w(NUM_ROWS);
    localparam int DW = NUM_COLS * ADC_BITS;
    localparam int EW = $clog2(ERASE_CYCLES + 1);
    localparam int TW = (EXP_W > EW) ? EXP_W : EW;

    localparam logic [RW-1:0]       ROW_LAST   = RW'(NUM_ROWS - 1);
    localparam logic [TW-1:0]       ERASE_LAST = TW'(ERASE_CYCLES - 1);
    localparam logic [NUM_ROWS-1:0] ROW_ONE    = 1;

    state_t           r_state;
    state_t           w_state_nx;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nx;
    logic [TW-1:0]    w_exp_last;
    logic [RW-1:0]    r_row;
    logic [RW-1:0]    w_row_nx;
    logic             r_settle;
    logic             w_settle_nx;
    logic [EXP_W-1:0] r_exp_len;
    logic [EXP_W-1:0] w_exp_in;
    logic             w_latch;
    logic             w_capture;
    logic             w_hs;
    logic             w_ramp_en;
    logic             w_ramp_clr;
    logic             w_ramp_tc;
    logic [DW-1:0]    w_cap_data;

    assign w_exp_in   = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;
    assign w_exp_last = TW'(r_exp_len - EXP_W'(1));
    assign w_ramp_en  = (r_state == CONVERT);
    assign w_ramp_clr = w_ramp_en && w_ramp_tc;

    pixel_ramp_counter #(
        .BITS (ADC_BITS)
    ) u_ramp (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_ramp_en),
        .i_clr  (w_ramp_clr),
        .o_code (adc_code),
        .o_tc   (w_ramp_tc)
    );

`ifdef PIXEL_TEST_PATTERN_EN
    logic r_test;

    // Row word source: synthetic index pattern or the array columns.
    always_comb begin
        w_cap_data = pix_data;
        if (r_test) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                w_cap_data[c*ADC_BITS +: ADC_BITS] =
                    ADC_BITS'(int'(r_row) * NUM_COLS + c);
            end
        end
    end

    // Test mode is frozen for the whole frame at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_test <= 1'b0;
        end else if (w_latch) begin
            r_test <= test_mode;
        end
    end
`else
    assign w_cap_data = pix_data;
`endif

    // Next-state, phase timer and row sequencing.
    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = r_timer;
        w_row_nx    = r_row;
        w_settle_nx = 1'b0;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_hs        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx = ERASE;
                    w_timer_nx = '0;
                    w_latch    = 1'b1;
                end
            end
            ERASE: begin
                if (r_timer == ERASE_LAST) begin
                    w_state_nx = EXPOSE;
                    w_timer_nx = '0;
                end else begin
                    w_timer_nx = r_timer + TW'(1);
                end
            end
            EXPOSE: begin
                if (r_timer == w_exp_last) begin
                    w_state_nx = CONVERT;
                    w_timer_nx = '0;
                end else begin
                    w_timer_nx = r_timer + TW'(1);
                end
            end
            CONVERT: begin
                if (w_ramp_tc) begin
                    w_state_nx = READ;
                    w_row_nx   = '0;
                end
            end
            READ: begin
                if (r_settle) begin
                    w_capture  = 1'b1;
                    w_state_nx = DRAIN;
                end else begin
                    w_settle_nx = 1'b1;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    w_hs = 1'b1;
                    if (r_row != ROW_LAST) begin
                        w_row_nx   = r_row + RW'(1);
                        w_state_nx = READ;
                    end else if (continuous) begin
                        w_row_nx   = '0;
                        w_timer_nx = '0;
                        w_latch    = 1'b1;
                        w_state_nx = ERASE;
                    end else begin
                        w_row_nx   = '0;
                        w_state_nx = IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State, counters and registered strobes/stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_row     <= '0;
            r_settle  <= 1'b0;
            r_exp_len <= '0;
            erase     <= 1'b0;
            ana_reset <= 1'b0;
            expose    <= 1'b0;
            convert   <= 1'b0;
            read_row  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_timer   <= w_timer_nx;
            r_row     <= w_row_nx;
            r_settle  <= w_settle_nx;
            erase     <= (w_state_nx == ERASE);
            ana_reset <= (w_state_nx == ERASE);
            expose    <= (w_state_nx == EXPOSE);
            convert   <= (w_state_nx == CONVERT);
            read_row  <= (w_state_nx == READ) ? (ROW_ONE << w_row_nx) : '0;
            busy      <= (w_state_nx != IDLE);
            if (w_latch) begin
                r_exp_len <= w_exp_in;
            end
            if (w_capture) begin
                out_data  <= w_cap_data;
                out_row   <= r_row;
                out_last  <= (r_row == ROW_LAST);
                out_valid <= 1'b1;
            end else if (w_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Directed bench for pixel_frame_ctrl (2x2 pixels, 8-bit ramp).
// Covers PIXEL_TEST_PATTERN_EN when that macro is defined.
module tb_pixel_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] expose_cycles = 16'd0;
`ifdef PIXEL_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif
    logic        erase;
    logic        ana_reset;
    logic        expose;
    logic        convert;
    logic [7:0]  adc_code;
    logic [1:0]  read_row;
    logic [15:0] pix_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic [0:0]  out_row;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] ROW0 = 16'hA1B2;
    localparam logic [15:0] ROW1 = 16'hC3D4;

    pixel_frame_ctrl #(
        .NUM_ROWS     (2),
        .NUM_COLS     (2),
        .ADC_BITS     (8),
        .ERASE_CYCLES (4),
        .EXP_W        (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .continuous    (continuous),
        .expose_cycles (expose_cycles),
`ifdef PIXEL_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .erase         (erase),
        .ana_reset     (ana_reset),
        .expose        (expose),
        .convert       (convert),
        .adc_code      (adc_code),
        .read_row      (read_row),
        .pix_data      (pix_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row       (out_row),
        .out_last      (out_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Pixel array model: each row drives its own fixed word when read.
    always_comb begin
        pix_data = 16'h5A5A;
        if (read_row[1]) pix_data = ROW1;
        else if (read_row[0]) pix_data = ROW0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0: return erase;
            1: return expose;
            2: return convert;
            3: return read_row[0];
            4: return read_row[1];
            default: return 1'b0;
        endcase
    endfunction

    // Count consecutive cycles a strobe stays high, bounded.
    task automatic run_phase(input int s, output int n, output bit rok);
        n = 0;
        rok = 1'b1;
        while (sig(s) && n < 4000) begin
            if (s == 2 && adc_code !== 8'(n)) rok = 1'b0;
            n++;
            tick();
        end
    endtask

    task automatic pulse_start(input logic [15:0] e);
        expose_cycles = e;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_read(output int ne, output int nx,
                               output int nc, output bit rok);
        bit d;
        run_phase(0, ne, d);
        run_phase(1, nx, d);
        run_phase(2, nc, rok);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({erase, ana_reset, expose, convert, adc_code, read_row,
             out_valid, out_data, out_row, out_last, busy} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b %b %b %b %h %b %b %h %b %b %b exp all 0",
                     erase, ana_reset, expose, convert, adc_code, read_row,
                     out_valid, out_data, out_row, out_last, busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || erase !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got busy=%b erase=%b exp 0 0", busy, erase);
        end
    endtask

    task automatic test_single_frame();
        int ne, nx, nc, nr;
        bit rok, d;
        out_ready = 1'b1;
        continuous = 1'b0;
        pulse_start(16'd10);
        checks++;
        if ({erase, ana_reset, expose, busy} !== 4'b1101) begin
            errors++;
            $display("FAIL erase_rise got %b exp 1101", {erase, ana_reset, expose, busy});
        end
        run_to_read(ne, nx, nc, rok);
        checks++;
        if (ne != 4) begin
            errors++;
            $display("FAIL erase_len got %0d exp 4", ne);
        end
        checks++;
        if (nx != 10) begin
            errors++;
            $display("FAIL expose_len got %0d exp 10", nx);
        end
        checks++;
        if (nc != 256 || !rok) begin
            errors++;
            $display("FAIL convert_ramp got len=%0d ramp_ok=%0d exp 256 1", nc, rok);
        end
        checks++;
        if ({read_row, adc_code} !== {2'b01, 8'h00}) begin
            errors++;
            $display("FAIL read0_start got rr=%b code=%h exp 01 00", read_row, adc_code);
        end
        run_phase(3, nr, d);
        checks++;
        if (nr != 2 || out_valid !== 1'b1 || out_row !== 1'b0 ||
            out_last !== 1'b0 || out_data !== ROW0 || read_row !== 2'b00) begin
            errors++;
            $display("FAIL row0_word got n=%0d v=%b r=%b l=%b d=%h rr=%b exp 2 1 0 0 %h 00",
                     nr, out_valid, out_row, out_last, out_data, read_row, ROW0);
        end
        tick();
        checks++;
        if (read_row !== 2'b10 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL row1_start got rr=%b v=%b exp 10 0", read_row, out_valid);
        end
        run_phase(4, nr, d);
        checks++;
        if (nr != 2 || out_valid !== 1'b1 || out_row !== 1'b1 ||
            out_last !== 1'b1 || out_data !== ROW1) begin
            errors++;
            $display("FAIL row1_word got n=%0d v=%b r=%b l=%b d=%h exp 2 1 1 1 %h",
                     nr, out_valid, out_row, out_last, out_data, ROW1);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_end got busy=%b v=%b exp 0 0", busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int ne, nx, nc, nr;
        bit rok, d, held_ok;
        logic [15:0] d0;
        out_ready = 1'b0;
        pulse_start(16'd3);
        run_to_read(ne, nx, nc, rok);
        checks++;
        if (nx != 3) begin
            errors++;
            $display("FAIL bp_expose_len got %0d exp 3", nx);
        end
        run_phase(3, nr, d);
        d0 = out_data;
        checks++;
        if (d0 !== ROW0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_row0 got d=%h v=%b exp %h 1", d0, out_valid, ROW0);
        end
        held_ok = 1'b1;
        repeat (20) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== d0 ||
                read_row !== 2'b00 || out_row !== 1'b0) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL bp_hold got held=%0d exp 1", held_ok);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (read_row !== 2'b10 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rr=%b v=%b exp 10 0", read_row, out_valid);
        end
        run_phase(4, nr, d);
        checks++;
        if (out_data !== ROW1 || out_last !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_row1 got d=%h l=%b v=%b exp %h 1 1",
                     out_data, out_last, out_valid, ROW1);
        end
        tick();
    endtask

    task automatic test_zero_exposure();
        int ne, nx, nc, n;
        bit rok;
        out_ready = 1'b1;
        pulse_start(16'd0);
        run_to_read(ne, nx, nc, rok);
        checks++;
        if (ne != 4 || nx != 1) begin
            errors++;
            $display("FAIL zero_expose got erase=%0d expose=%0d exp 4 1", ne, nx);
        end
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_finish got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_continuous();
        int ne, nx, nc, nr;
        bit rok, d, idle_ok;
        out_ready = 1'b1;
        continuous = 1'b1;
        pulse_start(16'd5);
        run_to_read(ne, nx, nc, rok);
        checks++;
        if (nx != 5) begin
            errors++;
            $display("FAIL cont_f1_expose got %0d exp 5", nx);
        end
        expose_cycles = 16'd7;
        run_phase(3, nr, d);
        tick();
        run_phase(4, nr, d);
        tick();
        checks++;
        if (erase !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cont_restart got erase=%b busy=%b v=%b exp 1 1 0",
                     erase, busy, out_valid);
        end
        expose_cycles = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_phase(0, ne, d);
        checks++;
        if (ne != 3) begin
            errors++;
            $display("FAIL cont_f2_erase got %0d exp 3", ne);
        end
        run_phase(1, nx, d);
        checks++;
        if (nx != 7) begin
            errors++;
            $display("FAIL cont_f2_expose got %0d exp 7", nx);
        end
        continuous = 1'b0;
        run_phase(2, nc, rok);
        run_phase(3, nr, d);
        tick();
        run_phase(4, nr, d);
        checks++;
        if (out_data !== ROW1 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL cont_f2_row1 got d=%h l=%b exp %h 1", out_data, out_last, ROW1);
        end
        tick();
        idle_ok = (busy === 1'b0 && erase === 1'b0);
        repeat (3) begin
            tick();
            if (busy !== 1'b0 || erase !== 1'b0) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("FAIL cont_stop got idle=%0d exp 1", idle_ok);
        end
    endtask

    task automatic test_reset_mid_convert();
        int ne, nx, nc, nr, n;
        bit rok, d;
        out_ready = 1'b1;
        continuous = 1'b0;
        pulse_start(16'd3);
        run_phase(0, ne, d);
        run_phase(1, nx, d);
        n = 0;
        while (adc_code !== 8'd100 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (adc_code !== 8'd100 || convert !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach got code=%0d conv=%b exp 100 1", adc_code, convert);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({erase, ana_reset, expose, convert, adc_code, read_row,
             out_valid, out_data, out_row, out_last, busy} !== 34'd0) begin
            errors++;
            $display("FAIL rst_mid got conv=%b code=%h busy=%b exp 0 00 0",
                     convert, adc_code, busy);
        end
        pulse_start(16'd6);
        run_to_read(ne, nx, nc, rok);
        checks++;
        if (ne != 4 || nx != 6 || nc != 256 || !rok) begin
            errors++;
            $display("FAIL rst_after got e=%0d x=%0d c=%0d ramp=%0d exp 4 6 256 1",
                     ne, nx, nc, rok);
        end
        run_phase(3, nr, d);
        checks++;
        if (out_data !== ROW0 || out_row !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_row0 got d=%h r=%b exp %h 0", out_data, out_row, ROW0);
        end
        tick();
        run_phase(4, nr, d);
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_end got busy=%b exp 0", busy);
        end
    endtask

`ifdef PIXEL_TEST_PATTERN_EN
    task automatic test_pattern();
        int ne, nx, nc, nr;
        bit rok, d;
        out_ready = 1'b1;
        test_mode = 1'b1;
        pulse_start(16'd2);
        test_mode = 1'b0;
        run_to_read(ne, nx, nc, rok);
        run_phase(3, nr, d);
        checks++;
        if (out_data !== 16'h0100) begin
            errors++;
            $display("FAIL pattern_row0 got %h exp 0100", out_data);
        end
        tick();
        run_phase(4, nr, d);
        checks++;
        if (out_data !== 16'h0302 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL pattern_row1 got %h l=%b exp 0302 1", out_data, out_last);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_zero_exposure();
        test_continuous();
        test_reset_mid_convert();
`ifdef PIXEL_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
